// File: rtl/byte_serializer.sv
// byte_serializer: accepts a parallel word over valid/ready and shifts it out
// as a framed serial stream (start bit, WIDTH data bits, stop bit).
module byte_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cyc_cnt, cyc_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic             sout_n, busy_n, done_n;
  logic             last_cyc;

  // Ready only while idle; accept happens on the edge that sees in_valid.
  assign in_ready = (state == IDLE);
  assign last_cyc = (cyc_cnt == CYC_LAST);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      sout    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      sout    <= sout_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state logic; outputs are computed from the next state so they line
  // up with the state they describe.
  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    sout_n  = 1'b1;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = START;
          shift_n = D;
          cyc_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (last_cyc) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cyc_n = CW'(cyc_cnt + 1'b1);
        end
      end
      DATA: begin
        if (last_cyc) begin
          cyc_n   = '0;
          shift_n = (LSB_FIRST != 0) ? (shift >> 1) : (shift << 1);
          if (bit_cnt == BIT_LAST) begin
            state_n = STOP;
          end else begin
            bit_n = BW'(bit_cnt + 1'b1);
          end
        end else begin
          cyc_n = CW'(cyc_cnt + 1'b1);
        end
      end
      STOP: begin
        if (last_cyc) begin
          cyc_n   = '0;
          state_n = IDLE;
        end else begin
          cyc_n = CW'(cyc_cnt + 1'b1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    unique case (state_n)
      IDLE:    sout_n = 1'b1;
      START:   sout_n = 1'b0;
      DATA:    sout_n = (LSB_FIRST != 0) ? shift_n[0] : shift_n[WIDTH-1];
      STOP:    sout_n = 1'b1;
      default: sout_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cyc_n == CYC_LAST);
  end

endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed checks of framing, handshake, reset abort and
// parameter variants (default, BIT_CYCLES=3, LSB_FIRST=0).
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [7:0] d_v [3];
  logic [2:0] valid_v;
  logic [2:0] ready_v;
  logic [2:0] sout_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(1)) u_def (
    .CLK(clk), .RST(rst_v[0]), .D(d_v[0]), .in_valid(valid_v[0]),
    .in_ready(ready_v[0]), .sout(sout_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  byte_serializer #(.WIDTH(8), .BIT_CYCLES(3), .LSB_FIRST(1)) u_bc3 (
    .CLK(clk), .RST(rst_v[1]), .D(d_v[1]), .in_valid(valid_v[1]),
    .in_ready(ready_v[1]), .sout(sout_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  byte_serializer #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(0)) u_msb (
    .CLK(clk), .RST(rst_v[2]), .D(d_v[2]), .in_valid(valid_v[2]),
    .in_ready(ready_v[2]), .sout(sout_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check a full frame on unit u starting in its first START cycle.
  task automatic frame(input int u, input logic [7:0] data, input int bc, input bit lsb);
    logic exp_bit;
    int   b;
    for (int i = 0; i < 10 * bc; i++) begin
      b = i / bc;
      if (b == 0)      exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else             exp_bit = lsb ? data[b-1] : data[8-b];
      chk($sformatf("u%0d_sout_c%0d", u, i + 1), sout_v[u], exp_bit);
      chk($sformatf("u%0d_busy_c%0d", u, i + 1), busy_v[u], 1'b1);
      chk($sformatf("u%0d_done_c%0d", u, i + 1), done_v[u], (i == 10 * bc - 1) ? 1'b1 : 1'b0);
      chk($sformatf("u%0d_ready_c%0d", u, i + 1), ready_v[u], 1'b0);
      step();
    end
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, "_sout"},  sout_v[u],  1'b1);
    chk({tag, "_busy"},  busy_v[u],  1'b0);
    chk({tag, "_done"},  done_v[u],  1'b0);
    chk({tag, "_ready"}, ready_v[u], 1'b1);
  endtask

  initial begin
    rst_v   = 3'b111;
    valid_v = 3'b111;
    d_v[0]  = 8'hA5;
    d_v[1]  = 8'hA5;
    d_v[2]  = 8'hA5;

    // 1: reset held two cycles with in_valid high
    step();
    chk("rst1_sout", sout_v[0], 1'b1);
    chk("rst1_busy", busy_v[0], 1'b0);
    chk("rst1_done", done_v[0], 1'b0);
    step();
    chk("rst2_sout", sout_v[0], 1'b1);
    chk("rst2_busy", busy_v[0], 1'b0);
    chk("rst2_done", done_v[0], 1'b0);
    chk("rst2_bc3_sout", sout_v[1], 1'b1);
    chk("rst2_msb_sout", sout_v[2], 1'b1);
    rst_v   = 3'b000;
    valid_v = 3'b000;
    #1;
    chk("post_rst_ready", ready_v[0], 1'b1);
    step();
    chk_idle(0, "post_rst_idle");

    // 2: single A5 frame, one-cycle valid
    d_v[0]     = 8'hA5;
    valid_v[0] = 1'b1;
    step();
    valid_v[0] = 1'b0;
    d_v[0]     = 8'h00;
    frame(0, 8'hA5, 1, 1'b1);
    chk_idle(0, "a5_after");

    // 3: valid held high, 3C then FF; D changes mid-frame ignored
    d_v[0]     = 8'h3C;
    valid_v[0] = 1'b1;
    step();
    d_v[0] = 8'hFF;
    frame(0, 8'h3C, 1, 1'b1);
    chk_idle(0, "b2b_gap");
    step();
    d_v[0]     = 8'h00;
    valid_v[0] = 1'b0;
    frame(0, 8'hFF, 1, 1'b1);
    chk_idle(0, "ff_after");
    step();
    chk_idle(0, "ff_after2");

    // 4: reset during data bit 4 of an 00 frame, then a clean 01 frame
    d_v[0]     = 8'h00;
    valid_v[0] = 1'b1;
    step();
    valid_v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("abort_sout_c%0d", i + 1), sout_v[0], 1'b0);
      chk($sformatf("abort_done_c%0d", i + 1), done_v[0], 1'b0);
      if (i < 5) step();
    end
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    chk("abort_rst_sout", sout_v[0], 1'b1);
    chk("abort_rst_busy", busy_v[0], 1'b0);
    chk("abort_rst_done", done_v[0], 1'b0);
    #1;
    chk("abort_rst_ready", ready_v[0], 1'b1);
    step();
    chk_idle(0, "abort_idle");
    d_v[0]     = 8'h01;
    valid_v[0] = 1'b1;
    step();
    valid_v[0] = 1'b0;
    frame(0, 8'h01, 1, 1'b1);
    chk_idle(0, "f01_after");

    // 5: BIT_CYCLES=3, 81 frame of 30 cycles
    d_v[1]     = 8'h81;
    valid_v[1] = 1'b1;
    step();
    valid_v[1] = 1'b0;
    frame(1, 8'h81, 3, 1'b1);
    chk_idle(1, "bc3_after");

    // 6: LSB_FIRST=0, C0 frame
    d_v[2]     = 8'hC0;
    valid_v[2] = 1'b1;
    step();
    valid_v[2] = 1'b0;
    frame(2, 8'hC0, 1, 1'b0);
    chk_idle(2, "msb_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
